// File: rtl/mul_pkg.sv
// Shared types and result slicing for the iterative RV32M-style multiplier.
package mul_pkg;

   // Upper bound on XLEN so slice_result can work on a fixed-width container.
   localparam int MAX_XLEN = 128;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011
   } mul_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } mul_state_e;

   function automatic mul_op_e decode_op(input logic [2:0] f);
      case (f)
         3'b001:  return OP_MULH;
         3'b010:  return OP_MULHSU;
         3'b011:  return OP_MULHU;
         default: return OP_MUL;
      endcase
   endfunction

   function automatic logic [MAX_XLEN-1:0] slice_result(input mul_op_e op,
                                                        input logic [2*MAX_XLEN-1:0] full,
                                                        input int unsigned xlen);
      logic [2*MAX_XLEN-1:0] w_hi;
      w_hi = full >> xlen;
      return (op == OP_MUL) ? full[MAX_XLEN-1:0] : w_hi[MAX_XLEN-1:0];
   endfunction

endpackage

// File: rtl/mul_radix_step.sv
// One radix-2^BPC iteration: adds multiplicand * mbits into the running product.
module mul_radix_step #(
   parameter int XLEN = 32,
   parameter int BPC  = 1
) (
   input  logic [2*XLEN-1:0] i_product,
   input  logic [2*XLEN-1:0] i_mcand,
   input  logic [BPC-1:0]    i_mbits,
   output logic [2*XLEN-1:0] o_product
);

   always_comb begin
      o_product = i_product;
      for (int i = 0; i < BPC; i++) begin
         if (i_mbits[i]) o_product = o_product + (i_mcand << i);
      end
   end

endmodule

// File: rtl/pipelined_serial_multiplier.sv
// Radix-2^BPC iterative multiplier with valid/ready handshakes, tag and flush.
// Optional early termination on an exhausted multiplier: PSMUL_EARLY_TERM_EN.
module pipelined_serial_multiplier #(
   parameter int XLEN  = 32,
   parameter int BPC   = 1,
   parameter int TAG_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic [2*XLEN-1:0] out_result_full,
   output logic [TAG_W-1:0]  out_tag,
   output logic              busy
);
   import mul_pkg::*;

   localparam int ITERS = XLEN / BPC;
   localparam int CNT_W = $clog2(ITERS) + 1;

   mul_state_e r_state, w_state_next;
   mul_op_e    r_op, w_op_in;

   logic [2*XLEN-1:0]     r_mcand, r_product, r_result_full;
   logic [XLEN-1:0]       r_mplier, r_result;
   logic [CNT_W-1:0]      r_count;
   logic                  r_sign;
   logic [TAG_W-1:0]      r_tag, r_out_tag;

   logic                  w_accept, w_last;
   logic                  w_a_neg, w_b_neg;
   logic [XLEN-1:0]       w_a_mag, w_b_mag, w_mplier_next;
   logic [2*XLEN-1:0]     w_prod_next, w_final;
   logic [2*MAX_XLEN-1:0] w_full_ext;
   logic [MAX_XLEN-1:0]   w_slice;
   logic                  w_unused;

   // Operand conditioning: signed operands are reduced to magnitude plus a result sign.
   assign w_op_in = decode_op(funct3);
   assign w_a_neg = (w_op_in != OP_MULHU) && op_a[XLEN-1];
   assign w_b_neg = ((w_op_in == OP_MUL) || (w_op_in == OP_MULH)) && op_b[XLEN-1];
   assign w_a_mag = w_a_neg ? -op_a : op_a;
   assign w_b_mag = w_b_neg ? -op_b : op_b;

   mul_radix_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
      .i_product (r_product),
      .i_mcand   (r_mcand),
      .i_mbits   (r_mplier[BPC-1:0]),
      .o_product (w_prod_next)
   );

   assign w_mplier_next = r_mplier >> BPC;
   assign w_final       = r_sign ? -w_prod_next : w_prod_next;

`ifdef PSMUL_EARLY_TERM_EN
   assign w_last = (r_count == CNT_W'(ITERS - 1)) || (w_mplier_next == '0);
`else
   assign w_last = (r_count == CNT_W'(ITERS - 1));
`endif

   always_comb begin
      w_full_ext = '0;
      w_full_ext[2*XLEN-1:0] = w_final;
   end
   assign w_slice  = slice_result(r_op, w_full_ext, XLEN);
   assign w_unused = ^w_slice[MAX_XLEN-1:XLEN];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Flush wins over both the last iteration and out_ready.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         ST_IDLE: if (in_valid && !flush) begin
            w_accept     = 1'b1;
            w_state_next = ST_BUSY;
         end
         ST_BUSY: begin
            if (flush)       w_state_next = ST_IDLE;
            else if (w_last) w_state_next = ST_DONE;
         end
         ST_DONE: if (flush || out_ready) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand       <= '0;
         r_mplier      <= '0;
         r_product     <= '0;
         r_count       <= '0;
         r_sign        <= 1'b0;
         r_op          <= OP_MUL;
         r_tag         <= '0;
         r_result_full <= '0;
         r_result      <= '0;
         r_out_tag     <= '0;
      end else if (w_accept) begin
         r_mcand   <= {{XLEN{1'b0}}, w_a_mag};
         r_mplier  <= w_b_mag;
         r_product <= '0;
         r_count   <= '0;
         r_sign    <= w_a_neg ^ w_b_neg;
         r_op      <= w_op_in;
         r_tag     <= in_tag;
      end else if (r_state == ST_BUSY) begin
         r_product <= w_prod_next;
         r_mcand   <= r_mcand << BPC;
         r_mplier  <= w_mplier_next;
         r_count   <= r_count + 1'b1;
         if (w_last && !flush) begin
            r_result_full <= w_final;
            r_result      <= w_slice[XLEN-1:0];
            r_out_tag     <= r_tag;
         end
      end
   end

   assign in_ready        = (r_state == ST_IDLE);
   assign busy            = (r_state != ST_IDLE);
   assign out_valid       = (r_state == ST_DONE);
   assign out_result      = r_result;
   assign out_result_full = r_result_full;
   assign out_tag         = r_out_tag;

endmodule

// File: tb/tb_pipelined_serial_multiplier.sv
// Directed bench for pipelined_serial_multiplier (XLEN=32, BPC=1 and BPC=4 instances).
module tb_pipelined_serial_multiplier;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0, in_valid4 = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] op_a = '0, op_b = '0, op_a4 = '0, op_b4 = '0;
   logic [4:0]  in_tag = '0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, busy;
   logic [31:0] out_result;
   logic [63:0] out_result_full;
   logic [4:0]  out_tag;
   logic        in_ready4, out_valid4, busy4;
   logic [31:0] out_result4;
   logic [63:0] out_result_full4;
   logic [4:0]  out_tag4;

   int checks = 0;
   int failures = 0;
   int lat;
   int vcount;

   always #5 clk = ~clk;

   pipelined_serial_multiplier #(.XLEN(32), .BPC(1), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .funct3(funct3), .op_a(op_a), .op_b(op_b), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_result_full(out_result_full), .out_tag(out_tag), .busy(busy)
   );

   pipelined_serial_multiplier #(.XLEN(32), .BPC(4), .TAG_W(5)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .funct3(funct3), .op_a(op_a4), .op_b(op_b4), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
      .out_result_full(out_result_full4), .out_tag(out_tag4), .busy(busy4)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [31:0] b, input int bpc);
`ifdef PSMUL_EARLY_TERM_EN
      int n = 0;
      int it;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
      it = (n + bpc - 1) / bpc;
      return (it == 0) ? 1 : it;
`else
      return 32 / bpc;
`endif
   endfunction

   // Called just after a rising edge with the DUT idle; returns edges until out_valid.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, output int l);
      funct3 = f; op_a = a; op_b = b; in_tag = t; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; op_a = 32'hDEADBEEF; op_b = 32'h5A5A5A5A; in_tag = 5'd31;
      l = 0;
      while (!out_valid && l < 100) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   task automatic run_op4(input logic [31:0] a, input logic [31:0] b, output int l);
      funct3 = 3'b000; op_a4 = a; op_b4 = b; in_tag = 5'd3; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0; op_a4 = '0; op_b4 = '0;
      l = 0;
      while (!out_valid4 && l < 100) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_result", out_result, 0);
      check_val("rst_full", out_result_full, 0);
      check_val("rst_tag", out_tag, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_busy", busy, 0);

      // MUL 7 * -3
      run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, lat);
      check_val("mul_lat", lat, exp_lat(32'h3, 1));
      check_val("mul_res", out_result, 64'hFFFFFFEB);
      check_val("mul_full", out_result_full, 64'hFFFFFFFF_FFFFFFEB);
      check_val("mul_tag", out_tag, 5);
      @(posedge clk); #1;
      check_val("mul_back_idle", in_ready, 1);

      run_op(3'b001, 32'h80000000, 32'h80000000, 5'd1, lat);
      check_val("mulh_res", out_result, 64'h40000000);
      check_val("mulh_full", out_result_full, 64'h40000000_00000000);
      @(posedge clk); #1;

      run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, lat);
      check_val("mulhu_res", out_result, 64'hFFFFFFFE);
      check_val("mulhu_full", out_result_full, 64'hFFFFFFFE_00000001);
      @(posedge clk); #1;

      run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, lat);
      check_val("mulhsu_res", out_result, 64'hFFFFFFFF);
      check_val("mulhsu_lo", out_result_full[31:0], 64'h00000001);
      @(posedge clk); #1;

      // Unused funct3 encoding behaves as MUL
      run_op(3'b111, 32'hFFFFFFFE, 32'd6, 5'd6, lat);
      check_val("f3_other_res", out_result, 64'hFFFFFFF4);
      @(posedge clk); #1;

      // Backpressure
      out_ready = 1'b0;
      run_op(3'b000, 32'd3, 32'd5, 5'd9, lat);
      for (int i = 0; i < 5; i++) begin
         check_val("bp_res", out_result, 15);
         check_val("bp_tag", out_tag, 9);
         check_val("bp_in_ready", in_ready, 0);
         check_val("bp_busy", busy, 1);
         check_val("bp_valid", out_valid, 1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check_val("bp_release_ready", in_ready, 1);
      check_val("bp_release_valid", out_valid, 0);

      // Flush at BUSY cycle 10
      funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6; in_tag = 5'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check_val("flush_busy", busy, 0);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) vcount++;
         @(posedge clk); #1;
      end
      check_val("flush_no_valid", vcount, 0);
      check_val("flush_res_kept", out_result, 15);

      // flush alongside a request in IDLE drops it
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check_val("flush_idle_drop", busy, 0);

      // Reset in the middle of an operation
      funct3 = 3'b000; op_a = 32'h1234; op_b = 32'h10; in_tag = 5'd8; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", out_valid, 0);
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_res", out_result, 0);
      check_val("mid_rst_full", out_result_full, 0);
      check_val("mid_rst_tag", out_tag, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(3'b000, 32'd3, 32'd4, 5'd10, lat);
      check_val("post_rst_res", out_result, 12);
      check_val("post_rst_tag", out_tag, 10);
      @(posedge clk); #1;

      // Latency depends on the multiplier only with early termination
      run_op(3'b000, 32'd5, 32'd3, 5'd11, lat);
      check_val("b3_lat", lat, exp_lat(32'd3, 1));
      check_val("b3_res", out_result, 15);
      @(posedge clk); #1;

      run_op(3'b000, 32'h1234, 32'd0, 5'd12, lat);
      check_val("b0_lat", lat, exp_lat(32'd0, 1));
      check_val("b0_res", out_result, 0);
      @(posedge clk); #1;

      // BPC=4 instance
      run_op4(32'h12345678, 32'h9, lat);
      check_val("bpc4_lat", lat, exp_lat(32'h9, 4));
      check_val("bpc4_res", out_result4, 64'hA3D70A38);
      check_val("bpc4_full", out_result_full4, 64'h00000000_A3D70A38);
      @(posedge clk); #1;

      run_op4(32'hFFFFFFF9, 32'h00000100, lat);
      check_val("bpc4_neg_lat", lat, exp_lat(32'h100, 4));
      check_val("bpc4_neg_res", out_result4, 64'hFFFFF900);
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_serial_multiplier.md
Name: pipelined_serial_multiplier

Overview:
- Parametrised successor to the team's bit-serial RV32M multiplier.
- Radix-2^BPC iterative multiplier (BPC = multiplier bits retired per cycle), generic operand width XLEN.
- Valid/ready handshakes on both sides, a transaction tag, and a flush input for pipeline kills.
- Sits beside the ALU in EX; the core stalls on !in_ready or busy.

Parameters:
- XLEN, 32: operand width. Must be even and ≥ 8.
- BPC, 1: multiplier bits per iteration. Legal values are 1, 2 and 4; XLEN % BPC must be 0.
- TAG_W, 5: tag width (destination register index).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, others treated as MUL
- op_a  in  XLEN  multiplicand (rs1)
- op_b  in  XLEN  multiplier (rs2)
- in_tag  in  TAG_W  tag carried with the request
- flush  in  1  abort the in-flight operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_result  out  XLEN  slice selected by funct3
- out_result_full  out  2*XLEN  full signed/unsigned product
- out_tag  out  TAG_W  tag of the result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all datapath registers 0; out_valid=0, out_result=0, out_result_full=0, out_tag=0. in_ready=1 once reset is released.
- States and transitions:
  - IDLE: in_ready=1. When in_valid=1, latch funct3/in_tag, magnitudes and sign; product=0; count=0; go to BUSY.
  - BUSY: each cycle:
    - product += multiplicand * multiplier[BPC-1:0]
    - multiplicand <<= BPC (2*XLEN wide)
    - multiplier >>= BPC (logical)
    - count++
    - On the last iteration (count == XLEN/BPC-1), register the final product, negated if sign, into out_result_full. Uses the combinational next product, so no extra cycle. Go to DONE.
  - DONE: out_valid=1; outputs held stable. When out_ready=1, go to IDLE. No same-cycle accept of a new request: in_ready=0 in DONE.
- Latency: request accepted at edge k; out_valid is high after edge k+XLEN/BPC. Defaults give 32 cycles.
- Sign rules:
  - MUL/MULH: sign = a_msb ^ b_msb; both operands as magnitudes.
  - MULHSU: sign = a_msb; op_b unsigned.
  - MULHU: sign = 0; both unsigned.
  - Magnitude of the most negative value is 2^(XLEN-1) as unsigned; this is correct with no overflow.
- Slicing: MUL gives low XLEN bits; MULH/MULHSU/MULHU give high XLEN bits.
- flush=1 in BUSY or DONE: return to IDLE next edge; out_valid drops; no result is produced.
- flush=1 coincident with in_valid in IDLE: the request is dropped.
- flush has priority over out_ready.
- Reset mid-operation: immediate return to the reset values above; no partial result is visible.
- Inputs are ignored outside the IDLE acceptance cycle. Changing op_a/op_b in BUSY has no effect.

Optional Feature:
- Macro: PSMUL_EARLY_TERM_EN.
- Defined: BUSY also finishes when the shifted multiplier becomes zero, with a minimum of 1 iteration. Latency becomes ceil((msb index of |b| + 1)/BPC); op_b=0 gives latency 1.
- Undefined: fixed XLEN/BPC latency, as stated above.

Decomposition:
- Shared package (mul_pkg):
  - mul_op_e enum for the funct3 encodings
  - state enum (IDLE/BUSY/DONE)
  - function slice_result(op, full)
- One sub-module, mul_radix_step: combinational BPC-bit partial product and accumulate (product, multiplicand, mbits → next product). Instantiated once.

Test Plan (defaults XLEN=32, BPC=1 unless stated):
- MUL, a=7, b=0xFFFFFFFD (-3), tag=5 → out_valid 32 cycles after accept; out_result=0xFFFFFFEB; out_result_full=0xFFFFFFFF_FFFFFFEB; out_tag=5.
- MULH, a=b=0x80000000 → 0x40000000. MULHU, a=b=0xFFFFFFFF → 0xFFFFFFFE, full=0xFFFFFFFE_00000001.
- MULHSU, a=0xFFFFFFFF (-1), b=0xFFFFFFFF → out_result=0xFFFFFFFF, full low word=0x00000001.
- Backpressure: out_ready=0 for 5 cycles after out_valid → result and tag stable, in_ready=0, busy=1; out_ready=1 → IDLE next edge, in_ready=1.
- flush at BUSY cycle 10 → no out_valid ever. rst_n low at cycle 20 of another operation → all outputs 0 immediately. A new MUL 3*4 afterwards returns 12.
- BPC=4, MUL 0x12345678*0x9 → 0x0A3D70A38 low=0xA3D70A38 after 8 cycles. With PSMUL_EARLY_TERM_EN, BPC=1, b=3 → out_valid after 2 cycles; b=0 → after 1 cycle, result 0.
